// File: rtl/alu_pkg.sv
// Shared front-panel ALU types: sequencer state codes (also shown on the phase LEDs)
// and the bit positions of the {N,Z,C,V} flags.
package alu_pkg;

   typedef enum logic [2:0] {
      GET_A  = 3'd0,
      GET_B  = 3'd1,
      GET_OP = 3'd2,
      EXEC   = 3'd3,
      SHOW   = 3'd4
   } seq_state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/btn_pulse.sv
// Rising-edge detector for a synchronous button; one press pulse per hold.
// The history register resets high so a button held through reset release stays silent.
module btn_pulse (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_press
);

   logic r_btn_q;

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_btn_q <= 1'b1;
      else     r_btn_q <= i_btn;
   end

   assign o_press = i_btn & ~r_btn_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-panel sequencer: collects A, B and opcode from switches, launches the ALU,
// waits ALU_LAT cycles and holds the result. Define ALU_SEQ_CHAIN_EN for accumulator mode.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int W       = 8,
   parameter int OPW     = 4,
   parameter int ALU_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           btn,
   input  logic [W-1:0]   sw,
   input  logic [OPW-1:0] op_sw,
   input  logic [W-1:0]   alu_result,
   input  logic [3:0]     alu_flags,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [OPW-1:0] alu_op,
   output logic           alu_start,
   output logic [W-1:0]   result_q,
   output logic [3:0]     flags_q,
   output logic           res_valid,
   output logic           busy,
   output logic [2:0]     phase
);

   localparam int            CW      = $clog2(ALU_LAT + 1);
   localparam logic [CW-1:0] LAT_C   = CW'(ALU_LAT);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   seq_state_t     r_state;
   seq_state_t     w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic [W-1:0]   r_alu_a;
   logic [W-1:0]   r_alu_b;
   logic [OPW-1:0] r_alu_op;
   logic [W-1:0]   r_result;
   logic [3:0]     r_flags;

   logic w_press;
   logic w_cap_a;
   logic w_cap_b;
   logic w_cap_op;
   logic w_cap_res;
   logic w_chain;

   btn_pulse u_btn_pulse (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn),
      .o_press (w_press)
   );

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      w_state_nxt = r_state;
      w_cap_a     = 1'b0;
      w_cap_b     = 1'b0;
      w_cap_op    = 1'b0;
      w_cap_res   = 1'b0;
      w_chain     = 1'b0;
      case (r_state)
         GET_A: if (w_press) begin
            w_cap_a     = 1'b1;
            w_state_nxt = GET_B;
         end
         GET_B: if (w_press) begin
            w_cap_b     = 1'b1;
            w_state_nxt = GET_OP;
         end
         GET_OP: if (w_press) begin
            w_cap_op    = 1'b1;
            w_state_nxt = EXEC;
         end
         EXEC: if (r_cnt == CNT_ONE) begin
            w_cap_res   = 1'b1;
            w_state_nxt = SHOW;
         end
         SHOW: if (w_press) begin
`ifdef ALU_SEQ_CHAIN_EN
            w_chain     = 1'b1;
            w_state_nxt = GET_B;
`else
            w_state_nxt = GET_A;
`endif
         end
         default: w_state_nxt = GET_A;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= GET_A;
         r_cnt    <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cap_a)       r_alu_a <= sw;
         else if (w_chain)  r_alu_a <= r_result;
         if (w_cap_b)       r_alu_b <= sw;
         if (w_cap_op)      r_alu_op <= op_sw;
         // Counter holds at zero outside EXEC so a stray state can never re-fire alu_start.
         if (w_cap_op)                                  r_cnt <= LAT_C;
         else if (r_state == EXEC && r_cnt != '0)       r_cnt <= r_cnt - CNT_ONE;
         if (w_cap_res) begin
            r_result <= alu_result;
            r_flags  <= alu_flags;
         end
      end
   end

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign result_q  = r_result;
   assign flags_q   = r_flags;
   assign alu_start = (r_state == EXEC) && (r_cnt == LAT_C);
   assign busy      = (r_state == EXEC);
   assign res_valid = (r_state == SHOW);
   assign phase     = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ALU_LAT=1 and 4) share the panel inputs;
// a step-level model plus a fake ALU supply expected values every cycle.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int LAT [2] = '{1, 4};

   logic clk = 1'b0;
   logic rst;
   logic btn;
   logic [7:0] sw;
   logic [3:0] op_sw;

   logic [1:0][7:0] res_in;
   logic [1:0][3:0] fl_in;
   logic [1:0][7:0] d_a, d_b, d_res;
   logic [1:0][3:0] d_op, d_fl;
   logic [1:0][2:0] d_phase;
   logic [1:0]      d_start, d_valid, d_busy;

   int checks = 0;
   int failures = 0;
   logic cmp_en;

   // step-level model: step 0..4 = A, B, opcode, computing, showing
   int         m_step [2];
   int         m_el   [2];
   logic [7:0] m_a [2], m_b [2], m_res [2];
   logic [3:0] m_op [2], m_fl [2];
   logic       m_btnq;

   int busy_cnt;
   int start_cnt;

   always #5 clk = ~clk;

   alu_op_sequencer #(.W(8), .OPW(4), .ALU_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .btn(btn), .sw(sw), .op_sw(op_sw),
      .alu_result(res_in[0]), .alu_flags(fl_in[0]),
      .alu_a(d_a[0]), .alu_b(d_b[0]), .alu_op(d_op[0]), .alu_start(d_start[0]),
      .result_q(d_res[0]), .flags_q(d_fl[0]), .res_valid(d_valid[0]),
      .busy(d_busy[0]), .phase(d_phase[0])
   );

   alu_op_sequencer #(.W(8), .OPW(4), .ALU_LAT(4)) u_dut4 (
      .clk(clk), .rst(rst), .btn(btn), .sw(sw), .op_sw(op_sw),
      .alu_result(res_in[1]), .alu_flags(fl_in[1]),
      .alu_a(d_a[1]), .alu_b(d_b[1]), .alu_op(d_op[1]), .alu_start(d_start[1]),
      .result_q(d_res[1]), .flags_q(d_fl[1]), .res_valid(d_valid[1]),
      .busy(d_busy[1]), .phase(d_phase[1])
   );

   // Fake ALU: correct sum only during the last computing cycle, junk otherwise.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         logic [8:0] s;
         s = {1'b0, m_a[i]} + {1'b0, m_b[i]};
         res_in[i] = 8'hEE;
         fl_in[i]  = 4'hF;
         if (m_step[i] == 3 && m_el[i] == LAT[i] - 1) begin
            res_in[i]         = s[7:0];
            fl_in[i]          = 4'h0;
            fl_in[i][FLAG_N]  = s[7];
            fl_in[i][FLAG_Z]  = (s[7:0] == 8'h00);
            fl_in[i][FLAG_C]  = s[8];
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_step[i] <= 0; m_el[i] <= 0;
            m_a[i] <= 0; m_b[i] <= 0; m_op[i] <= 0; m_res[i] <= 0; m_fl[i] <= 0;
         end
         m_btnq <= 1'b1;
      end else begin
         logic press;
         press = btn && !m_btnq;
         for (int i = 0; i < 2; i++) begin
            case (m_step[i])
               0: if (press) begin m_a[i] <= sw; m_step[i] <= 1; end
               1: if (press) begin m_b[i] <= sw; m_step[i] <= 2; end
               2: if (press) begin m_op[i] <= op_sw; m_step[i] <= 3; m_el[i] <= 0; end
               3: begin
                  m_el[i] <= m_el[i] + 1;
                  if (m_el[i] + 1 == LAT[i]) begin
                     m_res[i] <= res_in[i]; m_fl[i] <= fl_in[i]; m_step[i] <= 4;
                  end
               end
               default: if (press) begin
`ifdef ALU_SEQ_CHAIN_EN
                  m_a[i] <= m_res[i]; m_step[i] <= 1;
`else
                  m_step[i] <= 0;
`endif
               end
            endcase
         end
         m_btnq <= btn;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("alu_a[%0d]", i),     d_a[i],     m_a[i]);
            check($sformatf("alu_b[%0d]", i),     d_b[i],     m_b[i]);
            check($sformatf("alu_op[%0d]", i),    d_op[i],    m_op[i]);
            check($sformatf("result_q[%0d]", i),  d_res[i],   m_res[i]);
            check($sformatf("flags_q[%0d]", i),   d_fl[i],    m_fl[i]);
            check($sformatf("phase[%0d]", i),     d_phase[i], m_step[i]);
            check($sformatf("busy[%0d]", i),      d_busy[i],  m_step[i] == 3);
            check($sformatf("res_valid[%0d]", i), d_valid[i], m_step[i] == 4);
            check($sformatf("alu_start[%0d]", i), d_start[i], m_step[i] == 3 && m_el[i] == 0);
         end
         if (d_busy[1])  busy_cnt++;
         if (d_start[1]) start_cnt++;
      end
   end

   task automatic press(input logic [7:0] s, input logic [3:0] o);
      sw = s; op_sw = o; btn = 1'b1;
      @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; btn = 1'b1; sw = 8'h00; op_sw = 4'h0; cmp_en = 1'b0;
      busy_cnt = 0; start_cnt = 0;
      repeat (3) @(negedge clk);
      check("rst_phase", d_phase[1], 0);
      check("rst_start", d_start[1], 0);
      check("rst_result", d_res[0], 0);
      rst = 1'b0; cmp_en = 1'b1;

      // button still held after reset release: no press
      repeat (3) @(negedge clk);
      check("held_rst_phase", d_phase[0], 0);
      check("held_rst_a", d_a[0], 0);
      btn = 1'b0;
      @(negedge clk);

      // long hold produces exactly one capture
      sw = 8'h12; btn = 1'b1;
      repeat (10) @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
      check("hold10_phase", d_phase[0], 1);
      check("hold10_a", d_a[0], 8'h12);

      press(8'h34, 4'h0);
      busy_cnt = 0; start_cnt = 0;
      press(8'h00, 4'h3);
      check("lat1_op", d_op[0], 4'h3);
      check("lat1_b", d_b[0], 8'h34);
      check("lat1_result", d_res[0], 8'h46);
      check("lat1_flags", d_fl[0], 4'h0);
      check("lat1_valid", d_valid[0], 1);
      check("model_res_lat1", m_res[0], 8'h46);

      // press while the slow instance computes: ignored there, leaves SHOW on the fast one
      press(8'h99, 4'h0);
`ifdef ALU_SEQ_CHAIN_EN
      check("show_press_phase", d_phase[0], 1);
      check("show_press_a", d_a[0], 8'h46);
`else
      check("show_press_phase", d_phase[0], 0);
      check("show_press_a", d_a[0], 8'h12);
`endif
      check("lat4_still_busy", d_busy[1], 1);
      repeat (2) @(negedge clk);
      check("lat4_result", d_res[1], 8'h46);
      check("lat4_valid", d_valid[1], 1);
      check("lat4_busy_cycles", busy_cnt, 4);
      check("lat4_start_pulses", start_cnt, 1);

      // second pattern with carry out
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      press(8'hF0, 4'h0); press(8'h20, 4'h0); press(8'h00, 4'h5);
      repeat (4) @(negedge clk);
      check("carry_result", d_res[1], 8'h10);
      check("carry_flags", d_fl[1], 4'b0010);
      check("carry_op", d_op[1], 4'h5);

      // reset in the middle of computing (counter at 2)
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      press(8'h12, 4'h0); press(8'h34, 4'h0); press(8'h00, 4'h3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_phase", d_phase[1], 0);
      check("midrst_busy", d_busy[1], 0);
      check("midrst_a", d_a[1], 0);
      check("midrst_op", d_op[1], 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("midrst_no_latch", d_res[1], 0);
      check("midrst_no_valid", d_valid[1], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Front-panel controller for the FPGA ALU datapath.
- Steps the user through entering operand A, operand B and an opcode from board switches, one enter-button press per step.
- Launches the ALU, waits a fixed latency, then latches and holds the result and flags for display.
- Sits between the board switch/button inputs and the ALU core; it is the only driver of the ALU operand and opcode inputs.

## Interface
Parameters:
- W, 8, operand/result width in bits
- OPW, 4, opcode width in bits
- ALU_LAT, 1, ALU latency in cycles from alu_start to a valid alu_result; legal range 1..15

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-high
- btn  in  1  enter button, level, already synchronous to clk
- sw  in  W  switch value used as operand A or B
- op_sw  in  OPW  switch value used as opcode
- alu_result  in  W  ALU result
- alu_flags  in  4  ALU flags {N,Z,C,V}
- alu_a  out  W  operand A to the ALU (registered)
- alu_b  out  W  operand B to the ALU (registered)
- alu_op  out  OPW  opcode to the ALU (registered)
- alu_start  out  1  one-cycle launch pulse
- result_q  out  W  latched result
- flags_q  out  4  latched flags
- res_valid  out  1  high while in SHOW
- busy  out  1  high while in EXEC
- phase  out  3  current state code, for LEDs

## Operation
- Edge detect: press = btn & ~btn_q, where btn_q is btn delayed one cycle. btn_q resets to 1, so a button held through reset release does not fire.
- A held button produces exactly one press.
- States and phase codes: GET_A=0, GET_B=1, GET_OP=2, EXEC=3, SHOW=4. Reset state is GET_A.
- GET_A: on press, alu_a <= sw and go to GET_B.
- GET_B: on press, alu_b <= sw and go to GET_OP.
- GET_OP: on press, alu_op <= op_sw and go to EXEC; the latency counter is loaded with ALU_LAT.
- EXEC:
  - alu_start = 1 only in the first EXEC cycle.
  - The counter decrements each cycle.
  - On the edge where the counter reaches 1: result_q <= alu_result, flags_q <= alu_flags, go to SHOW.
  - Presses are ignored in EXEC and are not queued.
- SHOW: res_valid = 1 and all outputs are held. On press, go to GET_A (see Configuration).
- alu_a, alu_b and alu_op keep their values until they are overwritten by a later capture.
- Unreachable state codes recover to GET_A on the next edge, with all registers unchanged.
- rst asserted at any time, including mid-EXEC, forces every register to its reset value immediately.

## Timing
- Reset values: alu_a=0, alu_b=0, alu_op=0, result_q=0, flags_q=0, alu_start=0, busy=0, res_valid=0, phase=0, btn_q=1, counter=0.
- Capture latency: a value is captured at the same edge where press=1, i.e. the first edge at which btn is sampled high after being low. The new phase is visible after that edge.
- EXEC duration is exactly ALU_LAT cycles.
- busy is high for exactly ALU_LAT cycles.
- alu_result is sampled ALU_LAT edges after the edge that entered EXEC.
- The minimum time from the opcode press to res_valid is ALU_LAT cycles.
- alu_start is combinational from state/counter and contains no glitch-sensitive logic.

## Configuration
- ALU_SEQ_CHAIN_EN defined: a press in SHOW loads alu_a <= result_q and goes to GET_B, so results can be chained (accumulator mode).
- ALU_SEQ_CHAIN_EN undefined: a press in SHOW goes to GET_A and alu_a is unchanged.

## Structure
- Shared package alu_pkg holds:
  - the seq_state_t enum (logic [2:0], codes as above);
  - the flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module btn_pulse contains the btn_q register (reset to 1) and the press output. It is reused by other front-panel blocks.
- The counter width is $clog2(ALU_LAT+1).

## Test plan
- Reset, then btn held high across rst release -> no press; phase=0 and all outputs are 0.
- Basic entry, W=8, ALU_LAT=1: press with sw=0x12, press with sw=0x34, press with op_sw=0x3 -> alu_a=0x12, alu_b=0x34, alu_op=3, alu_start=1 for one cycle. Model alu_result=0x46, flags 0000 -> result_q=0x46 and res_valid=1 one cycle after entering EXEC.
- ALU_LAT=4: busy is high for exactly 4 cycles. A press during EXEC is ignored. The alu_result value changes only at the 4th edge, and result_q takes the value present at that edge.
- btn held for 10 cycles in GET_A -> exactly one capture; phase=1, not 2.
- rst pulsed mid-EXEC (ALU_LAT=4, counter=2) -> immediate return to GET_A with all outputs 0. The stale result is never latched.
- SHOW press, result_q=0x46: with ALU_SEQ_CHAIN_EN -> phase=1 and alu_a=0x46; without -> phase=0 and alu_a=0x12.
